// File: rtl/uart_rx_packer.sv
// uart_rx_packer: UART receiver that packs N_WORDS good characters into one valid/ready beat.
// Characters with framing or parity errors are dropped and restart packet assembly.
module uart_rx_packer #(
   parameter int CLOCKS_PER_PULSE = 2604,
   parameter int BITS_PER_WORD    = 8,
   parameter int N_WORDS          = 4,
   parameter int PARITY_MODE      = 0,
   parameter int STOP_BITS        = 1
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               rx,
   output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               err_frame,
   output logic                               err_parity,
   output logic                               err_overrun
);
   localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
   localparam int BW = $clog2(BITS_PER_WORD + 1);
   localparam int WW = $clog2(N_WORDS + 1);
   localparam int SW = $clog2(STOP_BITS + 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CW-1:0] FULL_END = CW'(CLOCKS_PER_PULSE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                                    state, state_next;
   logic                                      rx_meta, rx_sync, rx_prev, armed;
   logic [CW-1:0]                             cnt;
   logic [BW-1:0]                             bit_cnt;
   logic [SW-1:0]                             stop_cnt;
   logic [WW-1:0]                             word_cnt;
   logic [BITS_PER_WORD-1:0]                  data_sr;
   logic [N_WORDS-1:0][BITS_PER_WORD-1:0]     shadow;
   logic                                      par_bad, frame_bad, pkt_done;
   logic                                      tick, last_stop, frame_now;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) {rx_meta, rx_sync, rx_prev} <= 3'b111;
      else       {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // START resamples at half a bit so every later sample lands mid-bit
   always_comb begin
      tick       = (cnt == ((state == START) ? HALF_END : FULL_END));
      last_stop  = 1'b0;
      state_next = state;
      case (state)
         IDLE:    if (armed && rx_prev && !rx_sync) state_next = START;
         START:   if (tick) state_next = rx_sync ? IDLE : DATA;
         DATA:    if (tick && bit_cnt == BW'(BITS_PER_WORD - 1))
                     state_next = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:  if (tick) state_next = STOP;
         STOP:    if (tick && stop_cnt == SW'(STOP_BITS - 1)) begin
                     last_stop  = 1'b1;
                     state_next = IDLE;
                  end
         default: state_next = IDLE;
      endcase
   end

   assign frame_now = frame_bad | ~rx_sync;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt         <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= '0;
         word_cnt    <= '0;
         data_sr     <= '0;
         shadow      <= '0;
         par_bad     <= 1'b0;
         frame_bad   <= 1'b0;
         pkt_done    <= 1'b0;
         armed       <= 1'b1;
         m_data      <= '0;
         m_valid     <= 1'b0;
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_overrun <= 1'b0;
         pkt_done    <= 1'b0;
         cnt         <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
         bit_cnt     <= (state != DATA) ? '0 : bit_cnt + BW'(tick);
         stop_cnt    <= (state != STOP) ? '0 : stop_cnt + SW'(tick);
         if (state == DATA && tick) data_sr <= {rx_sync, data_sr[BITS_PER_WORD-1:1]};
         par_bad     <= (state == START) ? 1'b0 :
                        (state == PARITY && tick) ? (rx_sync ^ (^data_sr) ^ (PARITY_MODE == 2)) : par_bad;
         frame_bad   <= (state == START) ? 1'b0 :
                        (state == STOP && tick && !rx_sync) ? 1'b1 : frame_bad;
         // a low stop bit may be a held break; wait for the line to go high before rearming
         armed       <= (last_stop && frame_now) ? 1'b0 : (rx_sync ? 1'b1 : armed);
         if (last_stop) begin
            err_frame  <= frame_now;
            err_parity <= par_bad;
            if (frame_now || par_bad) word_cnt <= '0;
            else begin
               for (int i = 0; i < N_WORDS; i++)
                  if (word_cnt == WW'(i)) shadow[i] <= data_sr;
               pkt_done <= (word_cnt == WW'(N_WORDS - 1));
               word_cnt <= (word_cnt == WW'(N_WORDS - 1)) ? '0 : word_cnt + 1'b1;
            end
         end
         if (pkt_done) begin
            if (!m_valid || m_ready) begin
               m_data  <= shadow;
               m_valid <= 1'b1;
            end else err_overrun <= 1'b1;
         end else if (m_ready) m_valid <= 1'b0;
      end
   end
endmodule
